rgb_fade_pwm: RTL and testbench
===============================

// Module: rgb_fade_pwm
// PURPOSE
//  Generates NCH PWM duty streams for the iCE40 SB_RGBA_DRV PWM inputs, replacing constant ties.
//  Each channel is set by a valid/ready config port to static, linear fade, breathe or off.
//  Duty changes are glitch-free: they take effect only at a PWM period boundary.
//  Sits between user logic (touch pads, USB stack) and the LED driver hard macro.
// PARAMETERS
//  NCH      3      number of LED channels
//  PWM_W    8      PWM resolution, bits; period = 2^PWM_W clk cycles
//  DIV_W    16     width of per-channel fade step divider
// PORTS
//  clk         in   1               system clock (48 MHz, from global buffer)
//  rst_n       in   1               asynchronous active-low reset
//  cfg_valid   in   1               config request valid
//  cfg_ready   out  1               config can be accepted
//  cfg_ch      in   max(1,clog2(NCH)) target channel index
//  cfg_mode    in   2               00 STATIC, 01 FADE, 10 BREATHE, 11 OFF
//  cfg_level   in   PWM_W           static level / fade target / breathe peak
//  cfg_div     in   DIV_W           clk cycles per fade step; 0 treated as 1
//  cfg_err     out  1               1-cycle pulse: accepted request had cfg_ch >= NCH
//  pwm_out     out  NCH             registered PWM outputs to SB_RGBA_DRV
//  busy        out  NCH             channel is in FADE or BREATHE
//  done        out  NCH             1-cycle pulse when a FADE reaches its target
// BEHAVIOUR
//  Reset (async assert, sync release): cnt=0, cur[i]=0, duty[i]=0, state IDLE, pwm_out=0,
//   busy=0, done=0, cfg_err=0, cfg_ready=0. cfg_ready=1 from first clk edge after release.
//  PWM: free-running PWM_W counter cnt, wraps 2^PWM_W-1 -> 0. duty[i] <= cur[i] only in the
//   cycle cnt==2^PWM_W-1. pwm_out[i] <= (cnt < duty[i]) registered: duty 0 = always low,
//   duty all-ones = high 2^PWM_W-1 of 2^PWM_W cycles.
//  Handshake: accept on cfg_valid && cfg_ready (edge T). cfg_ready stays 1 (no backpressure
//   except in reset). cfg_ch >= NCH: request dropped, cfg_err=1 at T+1, no state change.
//  Per-channel FSM: IDLE, FADE, BR_UP, BR_DN. Accept at T, effects visible at T+1:
//   STATIC: cur=level, -> IDLE.  OFF: cur=0, -> IDLE.
//   FADE: tgt=level, divider=0; if cur==tgt -> IDLE and done at T+1, else -> FADE.
//   BREATHE: pk=level, divider=0; if pk==0 -> IDLE with cur=0, else -> BR_UP.
//  Divider: counts 0..max(cfg_div,1)-1, step tick on the terminal count, then restarts.
//  On tick: FADE: cur +/-1 toward tgt; on reaching tgt -> IDLE, done[i]=1 for 1 cycle.
//   BR_UP: cur+1; at cur==pk -> BR_DN. BR_DN: cur-1; at cur==0 -> BR_UP. Never wraps.
//   Entering BREATHE with cur>pk: BR_DN first. cur never exceeds 2^PWM_W-1 or goes below 0.
//  busy[i]=1 in FADE/BR_UP/BR_DN. New request to a busy channel aborts the current
//   operation (no done pulse), restarts from current cur with divider cleared.
//  Channels are independent; only one cfg per cycle so no same-channel conflicts.
//  Tick and period boundary in same cycle: duty takes cur value from before the tick.
//  Reset mid-operation: all state to reset values immediately; pwm_out low next cycle.
// TESTING
//  Reset: hold rst_n=0 with cnt running -> pwm_out=0, busy=0; cfg_ready=0 until release.
//  STATIC ch0 level 64 -> after next wrap exactly 64 high cycles per 256-cycle period; ch1/2 low.
//  FADE ch1 0->10, div 4 -> cur steps every 4 cycles, done[1] at 40 cycles after T+1, busy drops.
//  BREATHE ch2 pk 3, div 1 -> cur 0,1,2,3,2,1,0,1.. each cycle; busy stays 1; OFF -> 0, busy 0.
//  Abort: FADE ch0 0->200 div 2, after 20 cycles STATIC 5 -> no done, cur=5 at next cycle.
//  Bad channel: cfg_ch=3 (NCH=3) -> cfg_err pulse 1 cycle, all cur unchanged; div 0 acts as 1.

Source files
------------

// File: rtl/rgb_fade_pwm.sv
// rgb_fade_pwm: per-channel PWM duty generator (static, linear fade, breathe, off) feeding
// the SB_RGBA_DRV PWM inputs. Duty is latched only at the period wrap, so edges never glitch.
module rgb_fade_pwm #(
   parameter int NCH   = 3,
   parameter int PWM_W = 8,
   parameter int DIV_W = 16,
   localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CH_W-1:0]  cfg_ch,
   input  logic [1:0]       cfg_mode,
   input  logic [PWM_W-1:0] cfg_level,
   input  logic [DIV_W-1:0] cfg_div,
   output logic             cfg_err,
   output logic [NCH-1:0]   pwm_out,
   output logic [NCH-1:0]   busy,
   output logic [NCH-1:0]   done
);

   localparam logic [1:0] MODE_STATIC  = 2'b00;
   localparam logic [1:0] MODE_FADE    = 2'b01;
   localparam logic [1:0] MODE_BREATHE = 2'b10;
   localparam logic [1:0] MODE_OFF     = 2'b11;

   localparam logic [PWM_W-1:0] CNT_MAX = '1;
   localparam logic [PWM_W-1:0] ONE     = PWM_W'(1);

   typedef enum logic [1:0] {StIdle, StFade, StBrUp, StBrDn} state_e;

   logic [PWM_W-1:0] cnt;
   logic [PWM_W-1:0] cur     [NCH];
   logic [PWM_W-1:0] duty    [NCH];
   logic [PWM_W-1:0] tgt     [NCH];
   logic [PWM_W-1:0] pk      [NCH];
   logic [DIV_W-1:0] div_cnt [NCH];
   logic [DIV_W-1:0] div_lim [NCH];
   state_e           state   [NCH];

   logic             accept;
   logic             ch_ok;
   logic [DIV_W-1:0] div_eff;

   assign accept  = cfg_valid && cfg_ready;
   assign ch_ok   = int'(cfg_ch) < NCH;
   assign div_eff = (cfg_div == '0) ? DIV_W'(1) : cfg_div;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         cfg_ready <= 1'b0;
         cfg_err   <= 1'b0;
         pwm_out   <= '0;
         busy      <= '0;
         done      <= '0;
         for (int i = 0; i < NCH; i++) begin
            cur[i]     <= '0;
            duty[i]    <= '0;
            tgt[i]     <= '0;
            pk[i]      <= '0;
            div_cnt[i] <= '0;
            div_lim[i] <= DIV_W'(1);
            state[i]   <= StIdle;
         end
      end else begin
         cnt       <= cnt + ONE;
         cfg_ready <= 1'b1;
         cfg_err   <= accept && !ch_ok;
         for (int i = 0; i < NCH; i++) begin
            pwm_out[i] <= cnt < duty[i];
            // Latch the pre-tick cur so a same-cycle step lands in the next period
            if (cnt == CNT_MAX) duty[i] <= cur[i];
            done[i] <= 1'b0;
            if (accept && ch_ok && int'(cfg_ch) == i) begin
               div_cnt[i] <= '0;
               div_lim[i] <= div_eff;
               unique case (cfg_mode)
                  MODE_STATIC: begin
                     cur[i]   <= cfg_level;
                     state[i] <= StIdle;
                     busy[i]  <= 1'b0;
                  end
                  MODE_FADE: begin
                     tgt[i] <= cfg_level;
                     if (cur[i] == cfg_level) begin
                        state[i] <= StIdle;
                        busy[i]  <= 1'b0;
                        done[i]  <= 1'b1;
                     end else begin
                        state[i] <= StFade;
                        busy[i]  <= 1'b1;
                     end
                  end
                  MODE_BREATHE: begin
                     pk[i] <= cfg_level;
                     if (cfg_level == '0) begin
                        cur[i]   <= '0;
                        state[i] <= StIdle;
                        busy[i]  <= 1'b0;
                     end else begin
                        state[i] <= (cur[i] >= cfg_level) ? StBrDn : StBrUp;
                        busy[i]  <= 1'b1;
                     end
                  end
                  MODE_OFF: begin
                     cur[i]   <= '0;
                     state[i] <= StIdle;
                     busy[i]  <= 1'b0;
                  end
               endcase
            end else if (state[i] != StIdle) begin
               if (div_cnt[i] == div_lim[i] - DIV_W'(1)) begin
                  div_cnt[i] <= '0;
                  case (state[i])
                     StFade: begin
                        if (cur[i] < tgt[i]) begin
                           cur[i] <= cur[i] + ONE;
                           if (cur[i] + ONE == tgt[i]) begin
                              state[i] <= StIdle;
                              busy[i]  <= 1'b0;
                              done[i]  <= 1'b1;
                           end
                        end else begin
                           cur[i] <= cur[i] - ONE;
                           if (cur[i] - ONE == tgt[i]) begin
                              state[i] <= StIdle;
                              busy[i]  <= 1'b0;
                              done[i]  <= 1'b1;
                           end
                        end
                     end
                     StBrUp: begin
                        if (cur[i] >= pk[i]) begin
                           cur[i]   <= cur[i] - ONE;
                           state[i] <= StBrDn;
                        end else begin
                           cur[i] <= cur[i] + ONE;
                           if (cur[i] + ONE == pk[i]) state[i] <= StBrDn;
                        end
                     end
                     StBrDn: begin
                        if (cur[i] == '0) begin
                           cur[i]   <= ONE;
                           state[i] <= StBrUp;
                        end else begin
                           cur[i] <= cur[i] - ONE;
                           if (cur[i] == ONE) state[i] <= StBrUp;
                        end
                     end
                     default: ;
                  endcase
               end else begin
                  div_cnt[i] <= div_cnt[i] + DIV_W'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_rgb_fade_pwm.sv
// Bench for rgb_fade_pwm: directed scenarios plus randomized config traffic checked against
// a cycle-level behavioural model of the channel rules.
module tb_rgb_fade_pwm;

   localparam int NCH   = 3;
   localparam int PWM_W = 8;
   localparam int DIV_W = 16;
   localparam int CH_W  = 2;
   localparam int PER   = 1 << PWM_W;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             cfg_valid = 1'b0;
   logic [CH_W-1:0]  cfg_ch = '0;
   logic [1:0]       cfg_mode = '0;
   logic [PWM_W-1:0] cfg_level = '0;
   logic [DIV_W-1:0] cfg_div = '0;
   logic             cfg_ready;
   logic             cfg_err;
   logic [NCH-1:0]   pwm_out;
   logic [NCH-1:0]   busy;
   logic [NCH-1:0]   done;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   rgb_fade_pwm #(.NCH(NCH), .PWM_W(PWM_W), .DIV_W(DIV_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_mode  (cfg_mode),
      .cfg_level (cfg_level),
      .cfg_div   (cfg_div),
      .cfg_err   (cfg_err),
      .pwm_out   (pwm_out),
      .busy      (busy),
      .done      (done)
   );

   // Behavioural model: op 0 = idle, 1 = fade, 2 = breathe; m_ph counts cycles since last step
   int m_cnt, m_ready, m_err;
   int m_cur [NCH], m_duty [NCH], m_tgt [NCH], m_pk [NCH];
   int m_lim [NCH], m_ph [NCH], m_op [NCH], m_dir [NCH];
   int m_pwm [NCH], m_done [NCH];

   task automatic model_reset();
      m_cnt = 0; m_ready = 0; m_err = 0;
      for (int i = 0; i < NCH; i++) begin
         m_cur[i] = 0; m_duty[i] = 0; m_tgt[i] = 0; m_pk[i] = 0;
         m_lim[i] = 1; m_ph[i] = 0; m_op[i] = 0; m_dir[i] = 1;
         m_pwm[i] = 0; m_done[i] = 0;
      end
   endtask

   task automatic model_step();
      int acc;
      if (!rst_n) begin
         model_reset();
         return;
      end
      acc = (cfg_valid && m_ready != 0) ? 1 : 0;
      for (int i = 0; i < NCH; i++) begin
         m_pwm[i] = (m_cnt < m_duty[i]) ? 1 : 0;
         if (m_cnt == PER - 1) m_duty[i] = m_cur[i];
         m_done[i] = 0;
      end
      m_cnt = (m_cnt + 1) % PER;
      m_err = (acc != 0 && int'(cfg_ch) >= NCH) ? 1 : 0;
      for (int i = 0; i < NCH; i++) begin
         if (acc != 0 && int'(cfg_ch) == i) begin
            m_ph[i]  = 0;
            m_lim[i] = (cfg_div == 0) ? 1 : int'(cfg_div);
            case (cfg_mode)
               2'd0: begin m_cur[i] = int'(cfg_level); m_op[i] = 0; end
               2'd3: begin m_cur[i] = 0; m_op[i] = 0; end
               2'd1: begin
                  m_tgt[i] = int'(cfg_level);
                  if (m_cur[i] == m_tgt[i]) begin m_op[i] = 0; m_done[i] = 1; end
                  else m_op[i] = 1;
               end
               default: begin
                  m_pk[i] = int'(cfg_level);
                  if (m_pk[i] == 0) begin m_cur[i] = 0; m_op[i] = 0; end
                  else begin m_op[i] = 2; m_dir[i] = (m_cur[i] >= m_pk[i]) ? -1 : 1; end
               end
            endcase
         end else if (m_op[i] != 0) begin
            m_ph[i]++;
            if (m_ph[i] == m_lim[i]) begin
               m_ph[i] = 0;
               if (m_op[i] == 1) begin
                  m_cur[i] += (m_tgt[i] > m_cur[i]) ? 1 : -1;
                  if (m_cur[i] == m_tgt[i]) begin m_op[i] = 0; m_done[i] = 1; end
               end else begin
                  m_cur[i] += m_dir[i];
                  if (m_cur[i] >= m_pk[i]) m_dir[i] = -1;
                  else if (m_cur[i] <= 0) m_dir[i] = 1;
               end
            end
         end
      end
      m_ready = 1;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         model_step();
      end
   end

   // Stimulus helpers; called at a negedge, return at the negedge after the accept edge
   task automatic send(input int ch, input int mode, input int level, input int div);
      cfg_valid = 1'b1;
      cfg_ch    = CH_W'(ch);
      cfg_mode  = 2'(mode);
      cfg_level = PWM_W'(level);
      cfg_div   = DIV_W'(div);
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      repeat (4) begin
         @(negedge clk);
         n_tests++;
         if (cfg_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready: got %b want 0", cfg_ready);
         end
      end
      n_tests++;
      if (pwm_out !== '0 || busy !== '0 || done !== '0 || cfg_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outs: pwm %b busy %b done %b err %b want all 0",
                  pwm_out, busy, done, cfg_err);
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_tests++;
      if (cfg_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_release_ready: got %b want 1", cfg_ready);
      end
   endtask

   task automatic test_static();
      int h [NCH];
      do_reset();
      send(0, 0, 64, 1);
      repeat (300) @(negedge clk);
      for (int i = 0; i < NCH; i++) h[i] = 0;
      for (int k = 0; k < PER; k++) begin
         @(negedge clk);
         for (int i = 0; i < NCH; i++) h[i] += int'(pwm_out[i]);
      end
      for (int i = 0; i < NCH; i++) begin
         n_tests++;
         if (h[i] !== ((i == 0) ? 64 : 0)) begin
            n_fail++; $display("FAIL static_high_ch%0d: got %0d want %0d", i, h[i],
                               (i == 0) ? 64 : 0);
         end
      end
   endtask

   task automatic test_fade();
      int ndone, done_at, exp_cur;
      do_reset();
      send(1, 1, 10, 4);
      ndone = 0; done_at = -1;
      for (int k = 0; k <= 60; k++) begin
         if (k > 0) @(negedge clk);
         if (done[1]) begin ndone++; done_at = k; end
         exp_cur = (k / 4 > 10) ? 10 : k / 4;
         n_tests++;
         if (int'(dut.cur[1]) !== exp_cur) begin
            n_fail++; $display("FAIL fade_cur k=%0d: got %0d want %0d", k, dut.cur[1], exp_cur);
         end
         if (k == 39) begin
            n_tests++;
            if (busy[1] !== 1'b1) begin
               n_fail++; $display("FAIL fade_busy_mid: got %b want 1", busy[1]);
            end
         end
      end
      n_tests++;
      if (ndone !== 1 || done_at !== 40) begin
         n_fail++; $display("FAIL fade_done: got %0d pulses at %0d want 1 at 40", ndone, done_at);
      end
      n_tests++;
      if (busy[1] !== 1'b0) begin
         n_fail++; $display("FAIL fade_busy_end: got %b want 0", busy[1]);
      end
   endtask

   task automatic test_breathe();
      int exp_cur;
      do_reset();
      send(2, 2, 3, 1);
      for (int k = 0; k < 24; k++) begin
         if (k > 0) @(negedge clk);
         exp_cur = (k % 6 <= 3) ? k % 6 : 6 - k % 6;
         n_tests++;
         if (int'(dut.cur[2]) !== exp_cur || busy[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL breathe k=%0d: cur %0d busy %b want cur %0d busy 1", k, dut.cur[2],
                     busy[2], exp_cur);
         end
      end
      send(2, 3, 0, 0);
      n_tests++;
      if (dut.cur[2] !== '0 || busy[2] !== 1'b0) begin
         n_fail++; $display("FAIL breathe_off: cur %0d busy %b want 0 0", dut.cur[2], busy[2]);
      end
   endtask

   task automatic test_abort();
      int seen;
      do_reset();
      send(0, 1, 200, 2);
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (done[0]) seen++;
      end
      n_tests++;
      if (int'(dut.cur[0]) !== 10) begin
         n_fail++; $display("FAIL abort_pre_cur: got %0d want 10", dut.cur[0]);
      end
      send(0, 0, 5, 0);
      n_tests++;
      if (int'(dut.cur[0]) !== 5 || busy[0] !== 1'b0) begin
         n_fail++; $display("FAIL abort_cur: cur %0d busy %b want 5 0", dut.cur[0], busy[0]);
      end
      repeat (10) begin
         if (done[0]) seen++;
         @(negedge clk);
      end
      n_tests++;
      if (seen !== 0) begin
         n_fail++; $display("FAIL abort_done: got %0d pulses want 0", seen);
      end
   endtask

   task automatic test_bad_channel();
      int done_at;
      do_reset();
      send(0, 0, 7, 0);
      send(1, 0, 9, 0);
      send(3, 0, 99, 0);
      n_tests++;
      if (cfg_err !== 1'b1) begin
         n_fail++; $display("FAIL bad_ch_err: got %b want 1", cfg_err);
      end
      n_tests++;
      if (int'(dut.cur[0]) !== 7 || int'(dut.cur[1]) !== 9 || int'(dut.cur[2]) !== 0
          || busy !== '0) begin
         n_fail++;
         $display("FAIL bad_ch_state: cur %0d %0d %0d busy %b want 7 9 0 000", dut.cur[0],
                  dut.cur[1], dut.cur[2], busy);
      end
      @(negedge clk);
      n_tests++;
      if (cfg_err !== 1'b0) begin
         n_fail++; $display("FAIL bad_ch_err_pulse: got %b want 0", cfg_err);
      end
      send(0, 1, 10, 0);
      done_at = -1;
      for (int k = 0; k < 8; k++) begin
         if (k > 0) @(negedge clk);
         if (done[0] && done_at < 0) done_at = k;
      end
      n_tests++;
      if (done_at !== 3) begin
         n_fail++; $display("FAIL div_zero_done: got %0d want 3", done_at);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      send(1, 2, 200, 1);
      repeat (300) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if (pwm_out !== '0 || busy !== '0 || cfg_ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_mid: pwm %b busy %b ready %b want 000 000 0",
                            pwm_out, busy, cfg_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_tests++;
      if (cfg_ready !== 1'b1 || dut.cur[1] !== '0) begin
         n_fail++; $display("FAIL reset_mid_release: ready %b cur %0d want 1 0", cfg_ready,
                            dut.cur[1]);
      end
   endtask

   task automatic test_random();
      logic [NCH-1:0] e_pwm, e_busy, e_done;
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         for (int i = 0; i < NCH; i++) begin
            e_pwm[i]  = (m_pwm[i] != 0);
            e_busy[i] = (m_op[i] != 0);
            e_done[i] = (m_done[i] != 0);
            n_tests++;
            if (int'(dut.cur[i]) !== m_cur[i]) begin
               n_fail++; $display("FAIL rand_cur ch%0d cyc %0d: got %0d want %0d", i, k,
                                  dut.cur[i], m_cur[i]);
            end
         end
         n_tests++;
         if (pwm_out !== e_pwm || busy !== e_busy || done !== e_done
             || cfg_err !== (m_err != 0)) begin
            n_fail++;
            $display("FAIL rand_outs cyc %0d: pwm %b busy %b done %b err %b want %b %b %b %0d",
                     k, pwm_out, busy, done, cfg_err, e_pwm, e_busy, e_done, m_err);
         end
         cfg_valid = 1'b0;
         if ($urandom_range(7) == 0) begin
            cfg_valid = 1'b1;
            cfg_ch    = CH_W'($urandom_range(3));
            cfg_mode  = 2'($urandom_range(3));
            cfg_level = PWM_W'(($urandom_range(1) == 0) ? $urandom_range(255)
                                                        : $urandom_range(6));
            cfg_div   = DIV_W'($urandom_range(3));
         end
      end
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_static();
      test_fade();
      test_breathe();
      test_abort();
      test_bad_channel();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
